// File: rtl/muldiv_unit_pkg.sv
// Shared opcode and state definitions for the execute-stage multiply/divide unit.
// The decode controller and stall unit use the same MD_* opcode values.
package muldiv_unit_pkg;

    // Operation codes carried on MDctrE; codes 7..15 are undefined and do nothing.
    typedef enum logic [3:0] {
        MD_none  = 4'd0,
        MD_mult  = 4'd1,
        MD_multu = 4'd2,
        MD_div   = 4'd3,
        MD_divu  = 4'd4,
        MD_mthi  = 4'd5,
        MD_mtlo  = 4'd6
    } md_op_e;

    // IDLE means count==0, RUN means count!=0; no other state is held.
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_e;

    // True for the four opcodes that launch a multi-cycle operation.
    function automatic logic is_start_op(input logic [3:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            MD_mult, MD_multu, MD_div, MD_divu: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Operand, opcode and result bundle between the E stage and the mul/div unit.
// master = pipeline side (drives operands/opcode), slave = muldiv_unit.
interface muldiv_unit_if;

    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDctrE;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output A, B, MDctrE,
        input  start, busy, HI, LO
    );

    modport slave (
        input  A, B, MDctrE,
        output start, busy, HI, LO
    );

endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed on the start edge and parked in pending registers;
// a down-counter models the mult/div latency before HI/LO are written.
// MULT_CYCLES and DIV_CYCLES must both be at least 1.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;   // 0 for divide-by-zero: keep HI/LO
    md_state_e        state;
    logic             op_start;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic [31:0] divisor_u;

    assign state    = (count_q == '0) ? ST_IDLE : ST_RUN;
    assign op_start = (state == ST_IDLE) && is_start_op(md.MDctrE);

    assign md.start = op_start;
    assign md.busy  = op_start || (count_q != '0);
    assign md.HI    = hi_q;
    assign md.LO    = lo_q;

    // Arithmetic on the operands sampled this cycle; divides use magnitudes so
    // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of trapping.
    always_comb begin
        prod_s    = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
        prod_u    = {32'd0, md.A} * {32'd0, md.B};
        a_mag     = md.A[31] ? -md.A : md.A;
        b_mag     = md.B[31] ? -md.B : md.B;
        if (md.B == '0) begin
            b_mag = 32'd1;
        end
        q_mag     = a_mag / b_mag;
        r_mag     = a_mag % b_mag;
        quo_s     = (md.A[31] ^ md.B[31]) ? -q_mag : q_mag;
        rem_s     = md.A[31] ? -r_mag : r_mag;
        divisor_u = (md.B == '0) ? 32'd1 : md.B;
        quo_u     = md.A / divisor_u;
        rem_u     = md.A % divisor_u;
    end

    // Next-state logic: launch from IDLE, count down in RUN, commit on count==1.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state)
            ST_IDLE: begin
                case (md.MDctrE)
                    MD_mult: begin
                        {pend_hi_d, pend_lo_d} = prod_s;
                        pend_wr_d = 1'b1;
                        count_d   = CNT_W'(MULT_CYCLES);
                    end
                    MD_multu: begin
                        {pend_hi_d, pend_lo_d} = prod_u;
                        pend_wr_d = 1'b1;
                        count_d   = CNT_W'(MULT_CYCLES);
                    end
                    MD_div: begin
                        pend_hi_d = rem_s;
                        pend_lo_d = quo_s;
                        pend_wr_d = (md.B != '0);
                        count_d   = CNT_W'(DIV_CYCLES);
                    end
                    MD_divu: begin
                        pend_hi_d = rem_u;
                        pend_lo_d = quo_u;
                        pend_wr_d = (md.B != '0);
                        count_d   = CNT_W'(DIV_CYCLES);
                    end
                    MD_mthi: hi_d = md.A;
                    MD_mtlo: lo_d = md.A;
                    default: ;
                endcase
            end
            ST_RUN: begin
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1) && pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
            default: ;
        endcase
    end

    // State registers; reset also clears the pending result so an aborted op leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, signed/unsigned results,
// divide-by-zero, mthi/mtlo while idle and busy, and asynchronous reset.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   viol;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    muldiv_unit_if md_if();

    muldiv_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: a mult/div opcode presented while the unit refuses it.
    always @(negedge clk) begin
        if (!reset && is_start_op(md_if.MDctrE) && !md_if.start) begin
            viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_if.MDctrE = op;
        md_if.A      = a;
        md_if.B      = b;
    endtask

    // Launch a mult/div, measure busy cycles, check HI/LO before and after commit.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] e_hi, input logic [31:0] e_lo);
        int          cyc;
        logic [31:0] last_hi;
        logic [31:0] last_lo;
        step();
        drive(op, a, b);
        @(negedge clk);
        check({tag, "_start"}, md_if.start, 1);
        cyc     = 1;
        last_hi = md_if.HI;
        last_lo = md_if.LO;
        step();
        drive(MD_none, ~a, ~b);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!md_if.busy) break;
            cyc++;
            last_hi = md_if.HI;
            last_lo = md_if.LO;
            step();
        end
        check({tag, "_busy_cycles"}, 64'(cyc), 64'(n + 1));
        check({tag, "_hi_before"}, last_hi, model_hi);
        check({tag, "_lo_before"}, last_lo, model_lo);
        check({tag, "_hi"}, md_if.HI, e_hi);
        check({tag, "_lo"}, md_if.LO, e_lo);
        model_hi = e_hi;
        model_lo = e_lo;
    endtask

    // Single-cycle idle op (mthi/mtlo/none/undefined): no busy, HI/LO as expected next cycle.
    task automatic do_mt(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] e_hi, input logic [31:0] e_lo);
        step();
        drive(op, a, 32'h0);
        @(negedge clk);
        check({tag, "_busy"}, md_if.busy, 0);
        step();
        drive(MD_none, 32'h0, 32'h0);
        @(negedge clk);
        check({tag, "_hi"}, md_if.HI, e_hi);
        check({tag, "_lo"}, md_if.LO, e_lo);
        model_hi = e_hi;
        model_lo = e_lo;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        viol     = 0;
        model_hi = 32'h0;
        model_lo = 32'h0;
        reset    = 1'b1;
        drive(MD_none, 32'h0, 32'h0);
        #2;
        check("rst_hi", md_if.HI, 0);
        check("rst_lo", md_if.LO, 0);
        check("rst_busy", md_if.busy, 0);
        check("rst_start", md_if.start, 0);
        step();
        reset = 1'b0;

        // 1: signed and unsigned multiply
        do_op("mult_m1x2",  MD_mult,  32'hFFFFFFFF, 32'h2, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFE);
        do_op("multu_m1x2", MD_multu, 32'hFFFFFFFF, 32'h2, MULT_N, 32'h00000001, 32'hFFFFFFFE);
        do_op("mult_minsq", MD_mult,  32'h80000000, 32'h80000000, MULT_N, 32'h40000000, 32'h0);

        // 2: signed and unsigned divide
        do_op("div_m7d2",  MD_div,  32'hFFFFFFF9, 32'h2, DIV_N, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu_m7d2", MD_divu, 32'hFFFFFFF9, 32'h2, DIV_N, 32'h00000001, 32'h7FFFFFFC);
        do_op("div_7dm2",  MD_div,  32'h00000007, 32'hFFFFFFFE, DIV_N, 32'h00000001, 32'hFFFFFFFD);

        // 3: mthi/mtlo then divide by zero leaves HI/LO alone
        do_mt("mthi_idle", MD_mthi, 32'h1234, 32'h1234, model_lo);
        do_mt("mtlo_idle", MD_mtlo, 32'h5678, 32'h1234, 32'h5678);
        do_op("div_by0",  MD_div,  32'h5, 32'h0, DIV_N, 32'h1234, 32'h5678);
        do_op("divu_by0", MD_divu, 32'h5, 32'h0, DIV_N, 32'h1234, 32'h5678);

        // undefined code and MD_none change nothing
        do_mt("undef_op", 4'hF, 32'hFFFF_0000, 32'h1234, 32'h5678);
        do_mt("none_op",  MD_none, 32'hAAAA_5555, 32'h1234, 32'h5678);

        // 4: overflow case of signed divide
        do_op("div_ovf", MD_div, 32'h80000000, 32'hFFFFFFFF, DIV_N, 32'h0, 32'h80000000);

        // 5: mthi issued mid-multiply is ignored
        step();
        drive(MD_mult, 32'd3, 32'd4);          // cycle 0
        step();
        drive(MD_none, 32'h0, 32'h0);          // cycle 1
        step();
        drive(MD_mthi, 32'hDEAD, 32'h0);       // cycle 2
        @(negedge clk);
        check("mthi_busy_start", md_if.start, 0);
        check("mthi_busy_busy", md_if.busy, 1);
        step();
        drive(MD_none, 32'h0, 32'h0);          // cycle 3
        step();                                // cycle 4
        step();                                // cycle 5
        @(negedge clk);
        check("mthi_busy_hi_c5", md_if.HI, model_hi);
        check("mthi_busy_lo_c5", md_if.LO, model_lo);
        check("mthi_busy_busy_c5", md_if.busy, 1);
        step();                                // cycle 6
        @(negedge clk);
        check("mult3x4_hi", md_if.HI, 32'h0);
        check("mult3x4_lo", md_if.LO, 32'd12);
        check("mult3x4_busy", md_if.busy, 0);
        model_hi = 32'h0;
        model_lo = 32'd12;
        do_mt("mtlo_beef", MD_mtlo, 32'hBEEF, 32'h0, 32'hBEEF);

        // 6: asynchronous reset in the middle of a divide
        do_mt("mthi_pre_rst", MD_mthi, 32'hAAAA, 32'hAAAA, 32'hBEEF);
        step();
        drive(MD_div, 32'd100, 32'd7);         // cycle 0
        step();
        drive(MD_none, 32'h0, 32'h0);          // cycle 1
        step();                                // cycle 2
        step();                                // cycle 3
        step();                                // cycle 4
        #2;
        reset = 1'b1;
        #1;
        check("arst_hi", md_if.HI, 0);
        check("arst_lo", md_if.LO, 0);
        check("arst_busy", md_if.busy, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("post_rst_hi", md_if.HI, 0);
        check("post_rst_lo", md_if.LO, 0);
        check("post_rst_busy", md_if.busy, 0);
        model_hi = 32'h0;
        model_lo = 32'h0;
        do_op("mult_after_rst", MD_mult, 32'd3, 32'd4, MULT_N, 32'h0, 32'd12);

        check("protocol_violations", 64'(viol), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
